// File: rtl/usb11_host_txn_sched.sv
// usb11_host_txn_sched: host-side transaction sequencer feeding usb11_send.
// It builds a token packet (SYNC, PID, ADDR/ENDP, CRC5). For SETUP/OUT it
// follows with a data packet (SYNC, DATAx, 0..8 payload bytes, CRC16).
// It also enforces the frame-start window and the inter-packet gap.
module usb11_host_txn_sched #(
  parameter int unsigned START_MAX = 1300,
  parameter int unsigned START_MIN = 3,
  parameter int unsigned IPD_CLKS  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [3:0]  req_pid,
  input  logic [6:0]  req_addr,
  input  logic [3:0]  req_endp,
  input  logic [3:0]  req_dpid,
  input  logic [3:0]  req_len,
  output logic        ack,
  output logic        busy,
  output logic        done,
  output logic [2:0]  dbuf_addr,
  input  logic [7:0]  dbuf_data,
  output logic [7:0]  sbyte,
  output logic        sbyte_wr,
  output logic        last_pkt_byte,
  input  logic        show_next,
  input  logic        pkt_end,
  input  logic [10:0] ls_bit_time
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] WAIT_FRAME = 3'd1;
  localparam logic [2:0] TOK        = 3'd2;
  localparam logic [2:0] TOK_END    = 3'd3;
  localparam logic [2:0] GAP        = 3'd4;
  localparam logic [2:0] DAT        = 3'd5;
  localparam logic [2:0] DAT_END    = 3'd6;
  localparam logic [2:0] FIN        = 3'd7;

  localparam int         GAP_W       = (IPD_CLKS > 2) ? $clog2(IPD_CLKS) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(IPD_CLKS - 1);
  localparam logic [10:0] START_MIN_L = 11'(START_MIN);
  localparam logic [10:0] START_MAX_L = 11'(START_MAX);

  // Reflected CRC5 (poly 0x14) over {endp, addr}, addr[0] first, complemented.
  function automatic logic [4:0] crc5_calc(input logic [10:0] din);
    logic [4:0] c;
    c = 5'h1F;
    for (int i = 0; i < 11; i++) begin
      if (c[0] ^ din[i]) c = (c >> 1) ^ 5'h14;
      else               c = c >> 1;
    end
    return ~c;
  endfunction

  // Reflected CRC16 (poly 0xA001) advanced by one byte, LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] cin, input logic [7:0] b);
    logic [15:0] c;
    c = cin;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ b[i]) c = (c >> 1) ^ 16'hA001;
      else             c = c >> 1;
    end
    return c;
  endfunction

  logic [2:0]       state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [3:0]       pid_q, pid_d;
  logic [6:0]       addr_q, addr_d;
  logic [3:0]       endp_q, endp_d;
  logic [3:0]       dpid_q, dpid_d;
  logic [3:0]       len_q, len_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [15:0]      crc16_q, crc16_d;
  logic [7:0]       sbyte_q, sbyte_d;
  logic             sbyte_wr_q, sbyte_wr_d;
  logic             last_q, last_d;
  logic             ack_q, ack_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [3:0]       idx_nxt;
  logic [3:0]       idx_m1;
  logic [4:0]       crc5_val;

  assign crc5_val = crc5_calc({endp_q, addr_q});

  // Next-state, byte selection and CRC update for the transaction sequence.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pid_d      = pid_q;
    addr_d     = addr_q;
    endp_d     = endp_q;
    dpid_d     = dpid_q;
    len_d      = len_q;
    gap_d      = gap_q;
    crc16_d    = crc16_q;
    sbyte_d    = sbyte_q;
    sbyte_wr_d = 1'b0;
    last_d     = 1'b0;
    ack_d      = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    idx_nxt    = idx_q + 4'd1;
    case (state_q)
      IDLE: begin
        if (req) begin
          pid_d   = req_pid;
          addr_d  = req_addr;
          endp_d  = req_endp;
          dpid_d  = req_dpid;
          len_d   = (req_len > 4'd8) ? 4'd8 : req_len;
          ack_d   = 1'b1;
          busy_d  = 1'b1;
          state_d = WAIT_FRAME;
        end
      end
      WAIT_FRAME: begin
        if (!(ls_bit_time < START_MIN_L || ls_bit_time > START_MAX_L)) begin
          state_d    = TOK;
          idx_d      = 4'd0;
          sbyte_d    = 8'h80;
          sbyte_wr_d = 1'b1;
          crc16_d    = 16'hFFFF;
        end
      end
      TOK: begin
        if (show_next) begin
          idx_d      = idx_nxt;
          sbyte_wr_d = 1'b1;
          if (idx_nxt == 4'd1)      sbyte_d = {~pid_q, pid_q};
          else if (idx_nxt == 4'd2) sbyte_d = {endp_q[0], addr_q};
          else begin
            sbyte_d = {crc5_val, endp_q[3:1]};
            last_d  = 1'b1;
            state_d = TOK_END;
          end
        end
      end
      TOK_END: begin
        if (pkt_end) begin
          if (pid_q == 4'hD || pid_q == 4'h1) begin
            state_d = GAP;
            gap_d   = GAP_LOAD;
          end else begin
            state_d = FIN;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end
      GAP: begin
        // The strobe is registered, so DAT is entered as the counter reaches
        // zero; that puts the first data strobe IPD_CLKS cycles after pkt_end.
        gap_d = gap_q - GAP_W'(1);
        if (gap_q <= GAP_W'(1)) begin
          state_d    = DAT;
          idx_d      = 4'd0;
          sbyte_d    = 8'h80;
          sbyte_wr_d = 1'b1;
          crc16_d    = 16'hFFFF;
        end
      end
      DAT: begin
        if (show_next) begin
          idx_d      = idx_nxt;
          sbyte_wr_d = 1'b1;
          if (idx_nxt == 4'd1) sbyte_d = {~dpid_q, dpid_q};
          else if (idx_nxt <= len_q + 4'd1) begin
            sbyte_d = dbuf_data;
            crc16_d = crc16_byte(crc16_q, dbuf_data);
          end else if (idx_nxt == len_q + 4'd2) sbyte_d = ~crc16_q[7:0];
          else begin
            sbyte_d = ~crc16_q[15:8];
            last_d  = 1'b1;
            state_d = DAT_END;
          end
        end
      end
      DAT_END: begin
        if (pkt_end) begin
          state_d = FIN;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Payload read address points at the byte that the next show_next will send.
  always_comb begin
    idx_m1    = idx_q - 4'd1;
    dbuf_addr = 3'd0;
    if (state_q == DAT && idx_q != 4'd0 && idx_q <= len_q) dbuf_addr = idx_m1[2:0];
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= 4'd0;
      pid_q      <= 4'd0;
      addr_q     <= 7'd0;
      endp_q     <= 4'd0;
      dpid_q     <= 4'd0;
      len_q      <= 4'd0;
      gap_q      <= '0;
      crc16_q    <= 16'hFFFF;
      sbyte_q    <= 8'd0;
      sbyte_wr_q <= 1'b0;
      last_q     <= 1'b0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pid_q      <= pid_d;
      addr_q     <= addr_d;
      endp_q     <= endp_d;
      dpid_q     <= dpid_d;
      len_q      <= len_d;
      gap_q      <= gap_d;
      crc16_q    <= crc16_d;
      sbyte_q    <= sbyte_d;
      sbyte_wr_q <= sbyte_wr_d;
      last_q     <= last_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign sbyte         = sbyte_q;
  assign sbyte_wr      = sbyte_wr_q;
  assign last_pkt_byte = last_q;
  assign ack           = ack_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_usb11_host_txn_sched.sv
// Testbench for usb11_host_txn_sched: table of directed transactions plus
// hand-written sequences for frame wait, idle noise and mid-packet reset.
module tb_usb11_host_txn_sched;

  logic        clk;
  logic        rst;
  logic        req;
  logic [3:0]  req_pid;
  logic [6:0]  req_addr;
  logic [3:0]  req_endp;
  logic [3:0]  req_dpid;
  logic [3:0]  req_len;
  logic        ack;
  logic        busy;
  logic        done;
  logic [2:0]  dbuf_addr;
  logic [7:0]  dbuf_data;
  logic [7:0]  sbyte;
  logic        sbyte_wr;
  logic        last_pkt_byte;
  logic        show_next;
  logic        pkt_end;
  logic [10:0] ls_bit_time;

  logic [7:0]  dbuf_mem [0:7];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;

  usb11_host_txn_sched dut (
    .clk(clk), .rst(rst), .req(req), .req_pid(req_pid), .req_addr(req_addr),
    .req_endp(req_endp), .req_dpid(req_dpid), .req_len(req_len), .ack(ack),
    .busy(busy), .done(done), .dbuf_addr(dbuf_addr), .dbuf_data(dbuf_data),
    .sbyte(sbyte), .sbyte_wr(sbyte_wr), .last_pkt_byte(last_pkt_byte),
    .show_next(show_next), .pkt_end(pkt_end), .ls_bit_time(ls_bit_time)
  );

  assign dbuf_data = dbuf_mem[dbuf_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [3:0]  pid;
    logic [6:0]  addr;
    logic [3:0]  endp;
    logic [3:0]  dpid;
    logic [3:0]  len;
    logic [10:0] ls;
    logic [7:0]  seed;
    logic        has_data;
    int          npay;
    logic [7:0]  tok1;
    logic [7:0]  tok2;
    logic [7:0]  dpb;
  } vec_t;

  vec_t vecs [0:5];
  vec_t wvec;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Golden CRC5 in MSB-first form (poly 0x05), bit-reversed to the reflected result.
  function automatic logic [4:0] g_crc5(input logic [6:0] a, input logic [3:0] e);
    logic [10:0] d;
    logic [4:0]  n;
    logic [4:0]  r;
    logic        fb;
    d = {e, a};
    n = 5'h1F;
    for (int i = 0; i < 11; i++) begin
      fb = n[4] ^ d[i];
      n  = {n[3:0], 1'b0};
      if (fb) n = n ^ 5'h05;
    end
    for (int i = 0; i < 5; i++) r[i] = n[4-i];
    return ~r;
  endfunction

  // Golden CRC16 in MSB-first form (poly 0x8005) over dbuf_mem[0..n-1].
  function automatic logic [15:0] g_crc16(input int nbytes);
    logic [15:0] n;
    logic [15:0] r;
    logic [7:0]  b;
    logic        fb;
    n = 16'hFFFF;
    for (int k = 0; k < nbytes; k++) begin
      b = dbuf_mem[k];
      for (int i = 0; i < 8; i++) begin
        fb = n[15] ^ b[i];
        n  = {n[14:0], 1'b0};
        if (fb) n = n ^ 16'h8005;
      end
    end
    for (int i = 0; i < 16; i++) r[i] = n[15-i];
    return ~r;
  endfunction

  // Issue one request and act as usb11_send until done (or abort after abort_at strobes).
  task automatic run_txn(input vec_t v, input string tag, input int abort_at, input bit ls_run);
    logic [7:0]  exp_b [$];
    bit          exp_l [$];
    logic [15:0] c16;
    int nb, n_ack, ack_cyc, req_cyc, sn_at, pe_at, last_sn, last_pe, addr_bad, k;
    bit done_seen, aborted;
    logic [10:0] ls_prev;
    exp_b = {};
    exp_l = {};
    exp_b.push_back(8'h80);  exp_l.push_back(1'b0);
    exp_b.push_back(v.tok1); exp_l.push_back(1'b0);
    exp_b.push_back(v.tok2); exp_l.push_back(1'b0);
    exp_b.push_back({g_crc5(v.addr, v.endp), v.endp[3:1]}); exp_l.push_back(1'b1);
    if (v.has_data) begin
      exp_b.push_back(8'h80); exp_l.push_back(1'b0);
      exp_b.push_back(v.dpb); exp_l.push_back(1'b0);
      for (int i = 0; i < v.npay; i++) begin
        exp_b.push_back(dbuf_mem[i]); exp_l.push_back(1'b0);
      end
      c16 = g_crc16(v.npay);
      exp_b.push_back(c16[7:0]);  exp_l.push_back(1'b0);
      exp_b.push_back(c16[15:8]); exp_l.push_back(1'b1);
    end
    nb = 0; n_ack = 0; ack_cyc = -1000; sn_at = -1; pe_at = -1;
    last_sn = -1000; last_pe = -1000; addr_bad = 0; k = 0;
    done_seen = 0; aborted = 0;
    @(posedge clk); #1;
    if (!ls_run) ls_bit_time = v.ls;
    ls_prev  = ls_bit_time;
    req_pid  = v.pid; req_addr = v.addr; req_endp = v.endp;
    req_dpid = v.dpid; req_len = v.len; req = 1'b1;
    req_cyc  = cyc;
    while (k < 4000 && !done_seen && !aborted) begin
      k++;
      @(negedge clk);
      if (ack) begin
        n_ack++;
        if (n_ack == 1) begin
          ack_cyc = cyc;
          check({tag, " ack latency"}, cyc - req_cyc, 1);
          check({tag, " busy at ack"}, {31'd0, busy}, 1);
        end
      end
      if (!v.has_data && dbuf_addr != 3'd0) addr_bad++;
      if (sbyte_wr) begin
        if (nb < exp_b.size()) begin
          check($sformatf("%s byte%0d", tag, nb), {24'd0, sbyte}, {24'd0, exp_b[nb]});
          check($sformatf("%s last%0d", tag, nb), {31'd0, last_pkt_byte}, {31'd0, exp_l[nb]});
        end else begin
          check($sformatf("%s extra byte", tag), nb, exp_b.size());
        end
        if (nb == 0) begin
          if (ls_run) check({tag, " ls at start"}, {21'd0, ls_prev}, 3);
          else        check({tag, " start latency"}, cyc - ack_cyc, 1);
        end else if (nb == 4) begin
          check({tag, " gap clks"}, cyc - last_pe, 32);
        end else begin
          check($sformatf("%s sn->wr%0d", tag, nb), cyc - last_sn, 1);
        end
        if (last_pkt_byte) pe_at = cyc + 4;
        else               sn_at = cyc + 3;
        nb++;
        if (nb == abort_at) aborted = 1;
      end
      if (done) begin
        done_seen = 1;
        check({tag, " done latency"}, cyc - last_pe, 1);
        check({tag, " busy at done"}, {31'd0, busy}, 0);
      end
      ls_prev = ls_bit_time;
      if (!done_seen && !aborted) begin
        @(posedge clk); #1;
        show_next = 1'b0;
        pkt_end   = 1'b0;
        if (n_ack > 0) req = 1'b0;
        if (ls_run) ls_bit_time = (ls_bit_time == 11'd1499) ? 11'd0 : ls_bit_time + 11'd1;
        if (cyc == sn_at) begin show_next = 1'b1; last_sn = cyc; end
        if (cyc == pe_at) begin pkt_end = 1'b1; last_pe = cyc; end
      end
    end
    req = 1'b0;
    if (!aborted) begin
      check({tag, " done seen"}, {31'd0, done_seen}, 1);
      check({tag, " byte count"}, nb, exp_b.size());
      check({tag, " ack count"}, n_ack, 1);
      if (!v.has_data) check({tag, " dbuf_addr idle"}, addr_bad, 0);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " sbyte_wr"}, {31'd0, sbyte_wr}, 0);
    check({tag, " last"}, {31'd0, last_pkt_byte}, 0);
    check({tag, " ack"}, {31'd0, ack}, 0);
    check({tag, " busy"}, {31'd0, busy}, 0);
    check({tag, " done"}, {31'd0, done}, 0);
    check({tag, " sbyte"}, {24'd0, sbyte}, 0);
    check({tag, " dbuf_addr"}, {29'd0, dbuf_addr}, 0);
  endtask

  initial begin
    int n_wr, n_done, n_ack;
    rst = 1'b1; req = 1'b0; req_pid = 4'h0; req_addr = 7'h0; req_endp = 4'h0;
    req_dpid = 4'h0; req_len = 4'h0; show_next = 1'b0; pkt_end = 1'b0;
    ls_bit_time = 11'd10;
    for (int i = 0; i < 8; i++) dbuf_mem[i] = 8'h00;

    //            pid   addr   endp  dpid  len   ls       seed   data npay tok1   tok2   dpb
    vecs[0] = '{4'h9, 7'h15, 4'hE, 4'h3, 4'h0, 11'd10,   8'h00, 1'b0, 0, 8'h69, 8'h15, 8'hC3};
    vecs[1] = '{4'h1, 7'h01, 4'h0, 4'h3, 4'h0, 11'd10,   8'h00, 1'b1, 0, 8'hE1, 8'h01, 8'hC3};
    vecs[2] = '{4'hD, 7'h7F, 4'h1, 4'h3, 4'h8, 11'd500,  8'h00, 1'b1, 8, 8'h2D, 8'hFF, 8'hC3};
    vecs[3] = '{4'h1, 7'h22, 4'h3, 4'hB, 4'hF, 11'd1300, 8'h40, 1'b1, 8, 8'hE1, 8'hA2, 8'h4B};
    vecs[4] = '{4'h5, 7'h40, 4'h2, 4'h3, 4'h3, 11'd3,    8'h00, 1'b0, 0, 8'hA5, 8'h40, 8'hC3};
    vecs[5] = '{4'h1, 7'h0A, 4'h8, 4'hB, 4'h3, 11'd700,  8'h90, 1'b1, 3, 8'hE1, 8'h0A, 8'h4B};
    wvec    = '{4'h9, 7'h33, 4'h5, 4'h3, 4'h0, 11'd1400, 8'h00, 1'b0, 0, 8'h69, 8'hB3, 8'hC3};

    #1;
    check_outputs_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 8; i++) dbuf_mem[i] = vecs[v].seed + 8'(i);
      run_txn(vecs[v], $sformatf("vec%0d", v), -1, 1'b0);
    end

    // Stray show_next/pkt_end while idle must not start anything.
    n_wr = 0; n_done = 0; n_ack = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      show_next = i[0];
      pkt_end   = ~i[0];
      @(negedge clk);
      if (sbyte_wr) n_wr++;
      if (done) n_done++;
      if (ack) n_ack++;
    end
    @(posedge clk); #1;
    show_next = 1'b0; pkt_end = 1'b0;
    check("idle noise strobes", n_wr, 0);
    check("idle noise done", n_done, 0);
    check("idle noise ack", n_ack, 0);

    // Request outside the start window: waits until ls_bit_time wraps to 3.
    ls_bit_time = 11'd1400;
    run_txn(wvec, "frame wait", -1, 1'b1);

    // Reset in the middle of the data payload, then a normal transaction.
    for (int i = 0; i < 8; i++) dbuf_mem[i] = 8'(i);
    run_txn(vecs[2], "pre-reset", 8, 1'b0);
    show_next = 1'b0; pkt_end = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_outputs_zero("mid reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done || sbyte_wr) n_done++;
    end
    check("post reset quiet", n_done, 0);
    for (int i = 0; i < 8; i++) dbuf_mem[i] = vecs[1].seed + 8'(i);
    run_txn(vecs[1], "after reset", -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
